// File: rtl/program_loader_ctrl.sv
// Boot/test sequencer: streams a byte-serial program into imem while holding the core
// in reset, then runs the core and watches gp/a7 for the end-of-test ecall.
module program_loader_ctrl #(
  parameter int WIDTH          = 32,
  parameter int IMEM_DEPTH     = 512,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int PASS_A7        = 93
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [$clog2(IMEM_DEPTH):0]   numWords,
  input  logic                          byteValid,
  input  logic [7:0]                    byteData,
  output logic                          byteReady,
  input  logic [WIDTH-1:0]              gp,
  input  logic [WIDTH-1:0]              a7,
  output logic                          insMemEn,
  output logic [WIDTH-1:0]              insMemAddr,
  output logic [WIDTH-1:0]              insMemDataIn,
  output logic                          cpuReset,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic [31:0]                   cycleCount
);

  localparam int LW = $clog2(IMEM_DEPTH) + 1;
  localparam logic [LW-1:0]    DEPTH_L = LW'(IMEM_DEPTH);
  localparam logic [31:0]      TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [WIDTH-1:0] A7_END  = WIDTH'(PASS_A7);

  typedef enum logic [2:0] {IDLE, LOAD, RELEASE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     len_q, len_d, word_cnt_q, word_cnt_d, len_new;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic              ins_en_q, ins_en_d;
  logic [WIDTH-1:0]  ins_addr_q, ins_addr_d, ins_data_q, ins_data_d;
  logic              cpu_rst_q, cpu_rst_d, busy_q, busy_d, done_q, done_d;
  logic              pass_q, pass_d, timeout_q, timeout_d;
  logic [31:0]       cyc_q, cyc_d;
  logic              load_last;

  assign len_new   = (numWords > DEPTH_L) ? DEPTH_L : numWords;
  // The write cycle of the final word is the last LOAD cycle; bytes offered then are dropped.
  assign load_last = ins_en_q && (word_cnt_q == len_q);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    ins_en_d   = 1'b0;
    ins_addr_d = ins_addr_q;
    ins_data_d = ins_data_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    cyc_d      = cyc_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d      = len_new;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          cyc_d      = '0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          state_d    = (len_new != '0) ? LOAD : RELEASE;
        end
      end
      LOAD: begin
        if (load_last) begin
          state_d = RELEASE;
        end else if (byteValid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = byteData;
            2'd1: asm_d[15:8]  = byteData;
            2'd2: asm_d[23:16] = byteData;
            default: begin
              ins_en_d   = 1'b1;
              ins_addr_d = WIDTH'(word_cnt_q);
              ins_data_d = WIDTH'({byteData, asm_q});
              word_cnt_d = word_cnt_q + LW'(1);
            end
          endcase
        end
      end
      RELEASE: state_d = RUN;
      RUN: begin
        cyc_d = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
        if (a7 == A7_END) begin
          state_d   = DONE;
          pass_d    = (gp == WIDTH'(1));
          timeout_d = 1'b0;
        end else if (cyc_q == TO_LAST) begin
          state_d   = DONE;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    cpu_rst_d = (state_d != RUN);
    busy_d    = (state_d == LOAD) || (state_d == RELEASE) || (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      ins_en_q   <= 1'b0;
      ins_addr_q <= '0;
      ins_data_q <= '0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      ins_en_q   <= ins_en_d;
      ins_addr_q <= ins_addr_d;
      ins_data_q <= ins_data_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      cyc_q      <= cyc_d;
    end
  end

  assign byteReady    = (state_q == LOAD);
  assign insMemEn     = ins_en_q;
  assign insMemAddr   = ins_addr_q;
  assign insMemDataIn = ins_data_q;
  assign cpuReset     = cpu_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign cycleCount   = cyc_q;

endmodule

// File: tb/tb_program_loader_ctrl.sv
// Directed bench for program_loader_ctrl: load, pass/fail/timeout runs, clamped bulk load, reset mid-load.
module tb_program_loader_ctrl;
  localparam int DEPTH = 512;
  localparam int LW    = 10;

  logic          clock = 1'b0;
  logic          reset, start, byteValid;
  logic [LW-1:0] numWords;
  logic [7:0]    byteData;
  logic          byteReady, insMemEn, cpuReset, busy, done, pass, timeout;
  logic [31:0]   gp, a7, insMemAddr, insMemDataIn, cycleCount;

  int checks   = 0;
  int failures = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  program_loader_ctrl #(.WIDTH(32), .IMEM_DEPTH(DEPTH), .TIMEOUT_CYCLES(20), .PASS_A7(93)) dut (
    .clock(clock), .reset(reset), .start(start), .numWords(numWords),
    .byteValid(byteValid), .byteData(byteData), .byteReady(byteReady),
    .gp(gp), .a7(a7), .insMemEn(insMemEn), .insMemAddr(insMemAddr),
    .insMemDataIn(insMemDataIn), .cpuReset(cpuReset), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .cycleCount(cycleCount)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (insMemEn === 1'b1) begin
      wr_addr.push_back(insMemAddr);
      wr_data.push_back(insMemDataIn);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byteValid = 1'b0;
    for (int i = 0; i < gap; i++) tick();
    byteValid = 1'b1;
    byteData  = b;
    n = 0;
    while (byteReady !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) chk("byte_ready_wait", {31'd0, byteReady}, 32'd1);
    tick();
    byteValid = 1'b0;
  endtask

  task automatic pulse_start(input logic [LW-1:0] nw);
    numWords = nw;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  function automatic logic [31:0] pat(input int w);
    return 32'h9E37_79B9 * (w + 1);
  endfunction

  initial begin
    logic [7:0]  prog[8];
    logic [31:0] wv;
    int bad;
    prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    reset = 1'b1; start = 1'b0; numWords = '0; byteValid = 1'b0; byteData = '0;
    gp = '0; a7 = '0;
    tick(); tick();
    chk("rst_byteReady", {31'd0, byteReady}, 32'd0);
    chk("rst_insMemEn", {31'd0, insMemEn}, 32'd0);
    chk("rst_addr", insMemAddr, 32'd0);
    chk("rst_data", insMemDataIn, 32'd0);
    chk("rst_cpuReset", {31'd0, cpuReset}, 32'd1);
    chk("rst_flags", {28'd0, busy, done, pass, timeout}, 32'd0);
    chk("rst_cycleCount", cycleCount, 32'd0);
    reset = 1'b0;
    tick();

    // Two-word load, byteValid held high
    pulse_start(10'd2);
    chk("load_byteReady", {31'd0, byteReady}, 32'd1);
    chk("load_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) send_byte(prog[i], 0);
    chk("w1_en", {31'd0, insMemEn}, 32'd1);
    chk("w1_addr", insMemAddr, 32'd1);
    chk("w1_data", insMemDataIn, 32'h0010_0093);
    chk("w1_ready_during_write", {31'd0, byteReady}, 32'd1);
    tick();
    chk("rel_cpuReset", {31'd0, cpuReset}, 32'd1);
    chk("rel_en", {31'd0, insMemEn}, 32'd0);
    chk("rel_byteReady", {31'd0, byteReady}, 32'd0);
    tick();
    chk("run_cpuReset", {31'd0, cpuReset}, 32'd0);
    chk("wr_count2", wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      chk("w0_addr_q", wr_addr[0], 32'd0);
      chk("w0_data_q", wr_data[0], 32'h0000_0013);
      chk("w1_data_q", wr_data[1], 32'h0010_0093);
    end

    // Pass at cycle 10
    for (int i = 0; i < 10; i++) tick();
    chk("run_cyc10", cycleCount, 32'd10);
    a7 = 32'd93; gp = 32'd1;
    tick();
    a7 = 32'd0; gp = 32'd0;
    chk("pass_flags", {29'd0, done, pass, timeout}, 32'b110);
    chk("pass_cyc", cycleCount, 32'd11);
    chk("pass_cpuReset", {31'd0, cpuReset}, 32'd1);
    tick(); tick();
    chk("done_hold", {29'd0, done, pass, timeout}, 32'b110);
    chk("done_cyc_hold", cycleCount, 32'd11);

    // Fail: gp=5, rerun existing imem
    wr_addr.delete(); wr_data.delete();
    pulse_start(10'd0);
    chk("rerun_rel", {28'd0, busy, done, pass, cpuReset}, 32'b1001);
    chk("rerun_cyc_clr", cycleCount, 32'd0);
    tick();
    tick(); tick(); tick();
    a7 = 32'd93; gp = 32'd5;
    tick();
    a7 = 32'd0; gp = 32'd0;
    chk("fail_flags", {29'd0, done, pass, timeout}, 32'b100);
    chk("fail_cyc", cycleCount, 32'd4);
    chk("rerun_no_write", wr_addr.size(), 32'd0);

    // Timeout after 20 RUN cycles
    pulse_start(10'd0);
    tick();
    for (int i = 0; i < 19; i++) tick();
    chk("to_not_yet", {31'd0, done}, 32'd0);
    chk("to_cyc19", cycleCount, 32'd19);
    tick();
    chk("to_flags", {29'd0, done, pass, timeout}, 32'b101);
    chk("to_cyc", cycleCount, 32'd20);

    // a7 hit on the timeout edge: a7 wins
    pulse_start(10'd0);
    tick();
    for (int i = 0; i < 19; i++) tick();
    a7 = 32'd93; gp = 32'd1;
    tick();
    a7 = 32'd0; gp = 32'd0;
    chk("tie_flags", {29'd0, done, pass, timeout}, 32'b110);
    chk("tie_cyc", cycleCount, 32'd20);

    // Clamped bulk load with random gaps
    wr_addr.delete(); wr_data.delete();
    pulse_start(10'(DEPTH + 5));
    for (int w = 0; w < DEPTH; w++) begin
      wv = pat(w);
      for (int k = 0; k < 4; k++) send_byte(wv[8*k +: 8], $urandom_range(0, 2));
    end
    chk("bulk_last_en", {31'd0, insMemEn}, 32'd1);
    tick();
    chk("bulk_ready_after", {31'd0, byteReady}, 32'd0);
    chk("bulk_count", wr_addr.size(), 32'(DEPTH));
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] !== 32'(i) || wr_data[i] !== pat(i)) bad++;
    chk("bulk_bad_entries", bad, 32'd0);
    tick();
    chk("bulk_run", {31'd0, cpuReset}, 32'd0);
    pulse_start(10'd2);
    chk("start_ignored_run", {30'd0, byteReady, cpuReset}, 32'd0);

    // Reset mid-load after 6 bytes
    reset = 1'b1; tick(); reset = 1'b0; tick();
    wr_addr.delete(); wr_data.delete();
    pulse_start(10'd3);
    for (int i = 0; i < 6; i++) send_byte(prog[i], 0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst", {29'd0, cpuReset, busy, byteReady}, 32'b100);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("partial_writes", wr_addr.size(), 32'd1);
    pulse_start(10'd0);
    chk("zero_rel", {29'd0, busy, cpuReset, byteReady}, 32'b110);
    tick();
    chk("zero_run", {31'd0, cpuReset}, 32'd0);
    chk("zero_no_write", wr_addr.size(), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
